// File: rtl/temp_conv_pkg.sv
// Shared types and unit encodings for the temperature-conversion request sequencer.
package temp_conv_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   localparam logic UNIT_C2F = 1'b1;
   localparam logic UNIT_F2C = 1'b0;
endpackage

// File: rtl/temp_conv_ctrl_if.sv
// Request/response channels between the two requesters and the conversion sequencer.
interface temp_conv_ctrl_if #(parameter int VAL_W = 8);
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0][VAL_W-1:0] req_value;
   logic [1:0]            req_unit;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [VAL_W-1:0]      rsp_data;
   logic                  rsp_id;
   logic                  rsp_err;

   modport master (
      output req_valid, req_value, req_unit, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
   );

   modport slave (
      input  req_valid, req_value, req_unit, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
   );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; `last` remembers the most recently accepted requester.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic       grant
);
   logic last;

   always_comb begin
      case (valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         default: grant = ~last;
      endcase
   end

   // Reset to 1 so requester 0 wins the first contest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last <= 1'b1;
      else if (accept) last <= grant;
   end
endmodule

// File: rtl/temp_conv_ctrl.sv
// Sequences one conversion at a time from two requesters through the synchronous ROM.
module temp_conv_ctrl
   import temp_conv_pkg::*;
#(
   parameter int VAL_W  = 8,
   parameter int ADDR_W = 9,
   parameter int C_MAX  = 100,
   parameter int F_MIN  = 32,
   parameter int F_MAX  = 212,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   temp_conv_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_unit,
   output logic              rom_en,
   input  logic [VAL_W-1:0]  rom_data,
   output logic [CNT_W-1:0]  done_cnt,
   output logic [CNT_W-1:0]  err_cnt
);
   state_t            state;
   logic              grant;
   logic              accept;
   logic [VAL_W-1:0]  sel_value;
   logic              sel_unit;
   logic              in_range;
   logic [ADDR_W-1:0] map_addr;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (bus.req_valid),
      .accept (accept),
      .grant  (grant)
   );

   assign bus.req_ready = (state != IDLE) ? 2'b00 : (grant ? 2'b10 : 2'b01);
   assign accept        = |(bus.req_valid & bus.req_ready);
   assign sel_value     = bus.req_value[grant];
   assign sel_unit      = bus.req_unit[grant];

   // F->C entries sit directly after the C->F region; the range check keeps the subtraction positive.
   always_comb begin
      if (sel_unit == UNIT_C2F) begin
         in_range = int'(sel_value) <= C_MAX;
         map_addr = ADDR_W'(sel_value);
      end else begin
         in_range = (int'(sel_value) >= F_MIN) && (int'(sel_value) <= F_MAX);
         map_addr = ADDR_W'(C_MAX + 1) + (ADDR_W'(sel_value) - ADDR_W'(F_MIN));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rom_en        <= 1'b0;
         rom_addr      <= '0;
         rom_unit      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_id    <= 1'b0;
         bus.rsp_err   <= 1'b0;
         done_cnt      <= '0;
         err_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.rsp_id <= grant;
                  if (in_range) begin
                     rom_en   <= 1'b1;
                     rom_addr <= map_addr;
                     rom_unit <= sel_unit;
                     state    <= ISSUE;
                  end else begin
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_data  <= '0;
                     bus.rsp_valid <= 1'b1;
                     state         <= RESP;
                  end
               end
            end
            ISSUE: begin
               rom_en <= 1'b0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               bus.rsp_data  <= rom_data;
               bus.rsp_err   <= 1'b0;
               bus.rsp_valid <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
                  if (bus.rsp_err) begin
                     if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                  end else begin
                     if (done_cnt != '1) done_cnt <= done_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_temp_conv_ctrl.sv
// Directed bench for temp_conv_ctrl with a ROM model and a response scoreboard.
module tb_temp_conv_ctrl;
   typedef struct {
      logic [7:0] data;
      logic       id;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] rom_addr;
   logic       rom_unit;
   logic       rom_en;
   logic [7:0] rom_data;
   logic [3:0] done_cnt;
   logic [3:0] err_cnt;

   int   total = 0;
   int   bad = 0;
   int   exp_done = 0;
   int   exp_err = 0;
   int   acc_cnt = 0;
   exp_t sb[$];
   int   grant_q[$];

   temp_conv_ctrl_if #(.VAL_W(8)) bus ();

   temp_conv_ctrl #(.CNT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .rom_addr (rom_addr),
      .rom_unit (rom_unit),
      .rom_en   (rom_en),
      .rom_data (rom_data),
      .done_cnt (done_cnt),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] c2f(int v);
      int r;
      r = (v * 9) / 5 + 32;
      return r[7:0];
   endfunction

   function automatic logic [7:0] f2c(int v);
      int r;
      r = ((v - 32) * 5) / 9;
      return r[7:0];
   endfunction

   function automatic exp_t expect_of(int id, int v, logic u);
      exp_t e;
      e.id  = id[0];
      e.err = u ? (v > 100) : (v < 32 || v > 212);
      e.data = e.err ? 8'h00 : (u ? c2f(v) : f2c(v));
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Synchronous ROM; a unit that disagrees with the addressed region returns a poison value.
   always @(posedge clk) begin
      if (rom_en) begin
         if (rom_addr <= 9'd100) rom_data <= rom_unit ? c2f(int'(rom_addr)) : 8'hEE;
         else                    rom_data <= !rom_unit ? f2c(int'(rom_addr) - 101 + 32) : 8'hEE;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
               chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
               chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
               if (e.err) begin if (exp_err < 15) exp_err++; end
               else begin if (exp_done < 15) exp_done++; end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               sb.push_back(expect_of(i, int'(bus.req_value[i]), bus.req_unit[i]));
               grant_q.push_back(i);
               acc_cnt++;
            end
         end
      end
   end

   task automatic send(input int id, input int v, input logic u);
      int n;
      bus.req_valid[id] = 1'b1;
      bus.req_value[id] = v[7:0];
      bus.req_unit[id]  = u;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready[id] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      bus.req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output int pulses, output logic [8:0] a, output logic un);
      lat = 0; pulses = 0; a = '0; un = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (rom_en) begin
            pulses++;
            a  = rom_addr;
            un = rom_unit;
         end
         if (bus.rsp_valid) break;
      end
   endtask

   task automatic conv(input int id, input int v, input logic u, input int exp_lat,
                       input int exp_pulses, output logic [8:0] a, output logic un);
      int lat, pulses;
      send(id, v, u);
      wait_rsp(lat, pulses, a, un);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("rom_en pulses", 32'(pulses), 32'(exp_pulses));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [8:0] a;
      logic       un;
      int         lat, pulses, base, n;

      rst_n = 1'b0;
      bus.req_valid = '0; bus.req_value = '0; bus.req_unit = '0; bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst rom_en", 32'(rom_en), 32'd0);
      chk("rst rom_addr", 32'(rom_addr), 32'd0);
      chk("rst rom_unit", 32'(rom_unit), 32'd0);
      chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst done_cnt", 32'(done_cnt), 32'd0);
      chk("rst err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      bus.req_valid = 2'b11; #1;
      chk("first grant", 32'(bus.req_ready), 32'b01);
      bus.req_valid = 2'b00;
      @(posedge clk); #1;

      // Basic C->F from requester 0
      conv(0, 25, 1'b1, 3, 1, a, un);
      chk("c2f addr", 32'(a), 32'd25);
      chk("c2f unit", 32'(un), 32'd1);
      chk("done_cnt 1", 32'(done_cnt), 32'd1);

      // F->C top of range from requester 1
      conv(1, 212, 1'b0, 3, 1, a, un);
      chk("f2c addr 212", 32'(a), 32'd281);
      chk("f2c unit", 32'(un), 32'd0);

      // Out-of-range inputs take the short error path
      conv(1, 31, 1'b0, 1, 0, a, un);
      conv(0, 101, 1'b1, 1, 0, a, un);
      chk("err_cnt 2", 32'(err_cnt), 32'd2);

      // Range edges
      conv(0, 0, 1'b1, 3, 1, a, un);
      chk("c2f addr 0", 32'(a), 32'd0);
      conv(0, 100, 1'b1, 3, 1, a, un);
      chk("c2f addr 100", 32'(a), 32'd100);
      conv(1, 32, 1'b0, 3, 1, a, un);
      chk("f2c addr 32", 32'(a), 32'd101);
      conv(1, 213, 1'b0, 1, 0, a, un);
      chk("done_cnt model", 32'(done_cnt), 32'(exp_done));
      chk("err_cnt model", 32'(err_cnt), 32'(exp_err));

      // Response back-pressure
      bus.rsp_ready = 1'b0;
      send(0, 50, 1'b1);
      wait_rsp(lat, pulses, a, un);
      chk("stall latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("stall rsp_data", 32'(bus.rsp_data), 32'd122);
         chk("stall rsp_id", 32'(bus.rsp_id), 32'd0);
         chk("stall rsp_err", 32'(bus.rsp_err), 32'd0);
         chk("stall req_ready", 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall release", 32'(bus.rsp_valid), 32'd0);
      chk("stall done_cnt", 32'(done_cnt), 32'(exp_done));

      // Reset while the ROM read is being captured
      send(0, 60, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      chk("midrst rom_en", 32'(rom_en), 32'd0);
      chk("midrst rom_addr", 32'(rom_addr), 32'd0);
      chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("midrst done_cnt", 32'(done_cnt), 32'd0);
      chk("midrst err_cnt", 32'(err_cnt), 32'd0);
      chk("midrst dropped", 32'(sb.size()), 32'd1);
      sb.delete();
      exp_done = 0; exp_err = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no rsp after rst", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      conv(1, 100, 1'b0, 3, 1, a, un);
      chk("post-rst addr", 32'(a), 32'd169);
      chk("post-rst done_cnt", 32'(done_cnt), 32'd1);

      // Round robin with both requesters asserted from reset
      rst_n = 1'b0; #1;
      sb.delete(); grant_q.delete();
      exp_done = 0; exp_err = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      base = acc_cnt;
      bus.req_value[0] = 8'd10;  bus.req_unit[0] = 1'b1;
      bus.req_value[1] = 8'd50;  bus.req_unit[1] = 1'b0;
      bus.req_valid = 2'b11;
      n = 0;
      while (acc_cnt < base + 4 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      bus.req_valid = 2'b00;
      chk("rr accepts", 32'(acc_cnt - base), 32'd4);
      n = 0;
      while ((sb.size() != 0 || bus.rsp_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rr drained", 32'(sb.size()), 32'd0);
      chk("rr grant count", 32'(grant_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_q.size(); i++)
         chk("rr grant order", 32'(grant_q[i]), 32'(i % 2));
      chk("rr done_cnt", 32'(done_cnt), 32'd4);

      // Saturation with a 4-bit counter
      for (int i = 0; i < 20; i++) begin
         conv(i % 2, int'($urandom_range(0, 100)), 1'b1, 3, 1, a, un);
         chk("sat done model", 32'(done_cnt), 32'(exp_done));
      end
      chk("done_cnt saturated", 32'(done_cnt), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
